// File: rtl/ddr3_app_arbiter_if.sv
// ddr3_app_arbiter_if: app_* bus shared by two adapter ports, the arbiter and the MIG
interface ddr3_app_arbiter_if #(parameter int ADDR_W = 28, parameter int DATA_W = 128);
  logic init_calib_complete;
  logic [1:0] req, gnt, p_app_en, p_app_wdf_wren, p_app_wdf_end;
  logic [1:0] p_app_rdy, p_app_wdf_rdy, p_rd_data_valid;
  logic [1:0][2:0] p_app_cmd;
  logic [1:0][ADDR_W-1:0] p_app_addr;
  logic [1:0][DATA_W-1:0] p_app_wdf_data;
  logic [DATA_W-1:0] p_rd_data;
  logic app_en, app_wdf_wren, app_wdf_end, app_rdy, app_wdf_rdy, app_rd_data_valid;
  logic [2:0] app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data, app_rd_data;
  modport slave (
    input init_calib_complete, req, p_app_en, p_app_cmd, p_app_addr, p_app_wdf_wren,
          p_app_wdf_end, p_app_wdf_data, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    output gnt, p_app_rdy, p_app_wdf_rdy, p_rd_data_valid, p_rd_data,
           app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
  );
  modport master (
    output init_calib_complete, req, p_app_en, p_app_cmd, p_app_addr, p_app_wdf_wren,
           p_app_wdf_end, p_app_wdf_data, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data,
    input gnt, p_app_rdy, p_app_wdf_rdy, p_rd_data_valid, p_rd_data,
          app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data
  );
endinterface

// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter: round-robin burst arbiter for one MIG app port, with read-tag return steering
module ddr3_app_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 64
) (
  input  logic ui_clk,
  input  logic rst_n,
  ddr3_app_arbiter_if.slave bus,
  output logic [$clog2(TAG_DEPTH):0] rd_outstanding,
  output logic tag_err
);
  localparam int PW = $clog2(TAG_DEPTH);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nx;
  logic last, last_nx, g, act, rd_block, push, pop, head;
  logic [TAG_DEPTH-1:0] tags;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  always_ff @(posedge ui_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      last  <= last_nx;
    end
  // A finished grant hands straight to a waiting port only while calibration is still good
  always_comb begin
    state_nx = state;
    last_nx  = last;
    case (state)
      IDLE: if (bus.init_calib_complete)
        state_nx = &bus.req ? (last ? GNT0 : GNT1) : bus.req[0] ? GNT0 : bus.req[1] ? GNT1 : IDLE;
      GNT0: if (!bus.req[0]) begin
        last_nx  = 1'b0;
        state_nx = bus.req[1] && bus.init_calib_complete ? GNT1 : IDLE;
      end
      GNT1: if (!bus.req[1]) begin
        last_nx  = 1'b1;
        state_nx = bus.req[0] && bus.init_calib_complete ? GNT0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // A read may enter a full tag FIFO in the same cycle a beat returns and frees a slot
  always_comb begin
    act                 = state != IDLE;
    g                   = state == GNT1;
    bus.gnt             = {state == GNT1, state == GNT0};
    rd_block            = count == (PW+1)'(TAG_DEPTH) && act && bus.p_app_cmd[g] == 3'd1 && !bus.app_rd_data_valid;
    bus.app_en          = act && bus.p_app_en[g] && !rd_block;
    bus.app_wdf_wren    = act && bus.p_app_wdf_wren[g] && !rd_block;
    bus.app_wdf_end     = act && bus.p_app_wdf_end[g];
    bus.app_cmd         = act ? bus.p_app_cmd[g] : 3'd0;
    bus.app_addr        = act ? bus.p_app_addr[g] : '0;
    bus.app_wdf_data    = act ? bus.p_app_wdf_data[g] : '0;
    bus.p_app_rdy       = bus.gnt & {2{bus.app_rdy && !rd_block}};
    bus.p_app_wdf_rdy   = bus.gnt & {2{bus.app_wdf_rdy && !rd_block}};
    bus.p_rd_data       = bus.app_rd_data;
    bus.p_rd_data_valid = pop ? {head, !head} : 2'b00;
  end
  assign push = bus.app_en && bus.app_rdy && bus.app_cmd == 3'd1;
  assign pop  = bus.app_rd_data_valid && count != '0;
  assign head = tags[rd_ptr];
  assign rd_outstanding = count;
  always_ff @(posedge ui_clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      tag_err <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push);
      rd_ptr  <= rd_ptr + PW'(pop);
      count   <= count + (PW+1)'(push) - (PW+1)'(pop);
      tag_err <= tag_err || (bus.app_rd_data_valid && count == '0);
    end
  always_ff @(posedge ui_clk)
    if (push) tags[wr_ptr] <= g;
endmodule
